// File: rtl/threshold_frame_ctrl.sv
// threshold_frame_ctrl: streams a WIDTHxHEIGHT frame through a binary threshold into a 2-entry result FIFO.
// Define THRESH_CYCLE_COUNT_EN to build the busy-cycle counter behind cycle_count.
module threshold_frame_ctrl #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        threshold,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [31:0]       cycle_count
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t            r_state;
  logic [7:0]        r_thr;
  logic              r_inflight, r_wp, r_rp;
  logic [ADDR_W-1:0] r_rd_addr, r_if_addr;
  logic [1:0]        r_count;
  logic [7:0]        r_fd [2];
  logic [ADDR_W-1:0] r_fa [2];
  logic              w_pop, w_issue, w_fin;
  logic [1:0]        w_count_nxt;
  // The in-flight read lands in the FIFO this cycle, so it counts as occupied.
  assign wr_valid    = r_count != 2'd0;
  assign w_pop       = wr_valid && wr_ready;
  assign w_count_nxt = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_issue     = r_state == RUN && w_count_nxt < 2'd2;
  assign w_fin       = r_state == DRAIN && w_count_nxt == 2'd0;
  assign rd_en       = w_issue;
  assign rd_addr     = r_rd_addr;
  assign wr_data     = r_fd[r_rp];
  assign wr_addr     = r_fa[r_rp];
  assign busy        = r_state == RUN || r_state == DRAIN;
  assign done        = r_state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_thr      <= '0;
      r_inflight <= 1'b0;
      r_if_addr  <= '0;
      r_rd_addr  <= '0;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_count    <= '0;
      r_fd[0]    <= '0;
      r_fd[1]    <= '0;
      r_fa[0]    <= '0;
      r_fa[1]    <= '0;
    end else begin
      r_inflight <= w_issue;
      r_if_addr  <= r_rd_addr;
      r_count    <= w_count_nxt;
      if (r_inflight) begin
        r_fd[r_wp] <= rd_data > r_thr ? 8'hff : 8'h00;
        r_fa[r_wp] <= r_if_addr;
        r_wp       <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      if (w_issue) r_rd_addr <= r_rd_addr + 1'b1;
      case (r_state)
        IDLE: if (start) begin
          r_state   <= RUN;
          r_thr     <= threshold;
          r_rd_addr <= '0;
        end
        RUN:   if (w_issue && r_rd_addr == LAST) r_state <= DRAIN;
        DRAIN: if (w_fin) r_state <= DONE;
        DONE:  r_state <= IDLE;
      endcase
    end
  end
`ifdef THRESH_CYCLE_COUNT_EN
  logic [31:0] r_cnt, r_cycle_count;
  // The finishing DRAIN cycle is still busy, hence the +1 when freezing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_cycle_count <= '0;
    end else begin
      r_cnt <= (r_state == IDLE && start) ? 32'd0 : busy ? r_cnt + 32'd1 : r_cnt;
      if (w_fin) r_cycle_count <= r_cnt + 32'd1;
    end
  end
  assign cycle_count = r_cycle_count;
`else
  assign cycle_count = '0;
`endif
endmodule

// File: tb/tb_threshold_frame_ctrl.sv
// tb_threshold_frame_ctrl: directed frame scenarios against a pixel-level reference model.
module tb_threshold_frame_ctrl;
  localparam int W = 64, H = 64, AW = 12, N = W * H;
  logic          clk = 1'b0, rst, start, wr_ready;
  logic          busy, done, rd_en, wr_valid;
  logic [7:0]    threshold, rd_data, wr_data;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [31:0]   cycle_count;
  logic [7:0]    src [N];
  int            total = 0, passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_data <= src[rd_addr];

  threshold_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .cycle_count(cycle_count)
  );

  function automatic logic [7:0] ref_px(input logic [7:0] p, input logic [7:0] t);
    return p > t ? 8'd255 : 8'd0;
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < N; i++)
      src[i] = mode == 0 ? 8'(i) : mode == 1 ? 8'h00 : mode == 2 ? 8'hff : 8'($urandom);
  endtask

  // Runs one frame from an IDLE cycle and returns #1 into the IDLE cycle after done.
  task automatic frame(input string name, input logic [7:0] thr, input int rdy_pct,
                       input bit disturb, input bit hold);
    int nxt = 0, errs = 0, stab = 0, stalls = 0, done_c = -1, bad_a = -1;
    bit first_ok = 0, p_stall = 0, busy_at_done = 1;
    logic [7:0] p_d = '0;
    logic [AW-1:0] p_a = '0;
    logic [31:0] exp_cc;
    threshold = thr;
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c < 20000 && done_c < 0; c++) begin
      start = hold || (disturb && c >= 500 && c < 510);
      if (disturb && c >= 500) threshold = 8'd0;
      wr_ready = $urandom_range(99) < rdy_pct;
      @(negedge clk);
      if (c == 1) first_ok = busy && rd_en && rd_addr == '0;
      if (p_stall && (wr_addr !== p_a || wr_data !== p_d)) stab++;
      p_stall = wr_valid && !wr_ready;
      p_a = wr_addr;
      p_d = wr_data;
      if (p_stall) stalls++;
      if (wr_valid && wr_ready) begin
        if (nxt >= N || wr_addr !== AW'(nxt) || wr_data !== ref_px(src[nxt], thr)) begin
          errs++;
          if (bad_a < 0) bad_a = nxt;
        end
        nxt++;
      end
      if (done) begin
        done_c = c;
        busy_at_done = busy;
      end
      @(posedge clk); #1;
    end
`ifdef THRESH_CYCLE_COUNT_EN
    exp_cc = 32'(N + 2 + stalls);
`else
    exp_cc = 32'd0;
`endif
    total++;
    if (first_ok !== 1'b1) $display("FAIL %s_first_read: busy/rd_en/rd_addr=0 at cycle 1 got %0b, required 1", name, first_ok);
    else passed++;
    total++;
    if (errs !== 0) $display("FAIL %s_data: %0d bad writes (first at index %0d), required 0", name, errs, bad_a);
    else passed++;
    total++;
    if (nxt !== N) $display("FAIL %s_write_count: got %0d, required %0d", name, nxt, N);
    else passed++;
    total++;
    if (stab !== 0) $display("FAIL %s_stall_stable: %0d unstable stall cycles, required 0", name, stab);
    else passed++;
    total++;
    if (done_c !== N + 3 + stalls) $display("FAIL %s_done_cycle: got %0d, required %0d", name, done_c, N + 3 + stalls);
    else passed++;
    total++;
    if (busy_at_done !== 1'b0) $display("FAIL %s_busy_at_done: got %0b, required 0", name, busy_at_done);
    else passed++;
    total++;
    if (cycle_count !== exp_cc) $display("FAIL %s_cycle_count: got %0d, required %0d", name, cycle_count, exp_cc);
    else passed++;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL %s_after_done: done=%0b busy=%0b, required 0 0", name, done, busy);
    else passed++;
    if (!hold) start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    wr_ready = 1'b0;
    threshold = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, rd_en, rd_addr, wr_valid, wr_addr, wr_data, cycle_count} !== '0)
      $display("FAIL reset_values: busy=%0b done=%0b rd_en=%0b rd_addr=%0d wr_valid=%0b wr_addr=%0d wr_data=%0d cc=%0d, required all 0",
               busy, done, rd_en, rd_addr, wr_valid, wr_addr, wr_data, cycle_count);
    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp;
    fill(0);
    frame("ramp", 8'd128, 100, 1'b0, 1'b0);
  endtask

  task automatic test_thresholds;
    fill(1);
    frame("zero_thr0", 8'd0, 100, 1'b0, 1'b0);
    fill(2);
    frame("ff_thr255", 8'd255, 100, 1'b0, 1'b0);
    frame("ff_thr254", 8'd254, 100, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    fill(3);
    frame("random_bp", 8'($urandom), 50, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_changes;
    fill(3);
    frame("ignore_midframe", 8'd128, 100, 1'b1, 1'b0);
  endtask

  task automatic test_mid_reset;
    int c = 0;
    bit seen = 0;
    fill(0);
    threshold = 8'd128;
    wr_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    while (!(rd_en && rd_addr == AW'(1000)) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (c >= 3000) $display("FAIL mid_reset_reach_1000: rd_addr=%0d after %0d cycles, required 1000", rd_addr, c);
    else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy, done, rd_en, rd_addr, wr_valid, wr_addr, wr_data, cycle_count} !== '0)
      $display("FAIL mid_reset_values: busy=%0b done=%0b rd_en=%0b rd_addr=%0d wr_valid=%0b wr_addr=%0d wr_data=%0d cc=%0d, required all 0",
               busy, done, rd_en, rd_addr, wr_valid, wr_addr, wr_data, cycle_count);
    else passed++;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL mid_reset_quiet: done/busy seen=%0b, required 0", seen);
    else passed++;
    @(posedge clk); #1;
    frame("after_reset", 8'd128, 100, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    fill(3);
    frame("b2b_first", 8'd50, 100, 1'b0, 1'b1);
    frame("b2b_second", 8'd200, 100, 1'b0, 1'b1);
    start = 1'b0;
  endtask

  initial begin
    test_reset;
    test_ramp;
    test_thresholds;
    test_backpressure;
    test_ignore_changes;
    test_mid_reset;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
